// File: rtl/hamming_secded_decoder_pipe_if.sv
// rtl/hamming_secded_decoder_pipe_if.sv - code-word input and corrected-data output streams of the SEC-DED decoder
interface hamming_secded_decoder_pipe_if #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4
);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              err_single;
  logic              err_double;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, err_single, err_double
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, err_single, err_double
  );
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// rtl/hamming_secded_decoder_pipe.sv - 2-stage Hamming SEC-DED decoder with valid/ready streams and saturating event counters
module hamming_secded_decoder_pipe #(
  parameter int DATA_W  = 8,
  parameter int PAR_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hamming_secded_decoder_pipe_if.slave bus,
  input  logic                        clr_counts,
  output logic [COUNT_W-1:0]          sec_count,
  output logic [COUNT_W-1:0]          ded_count
);
  localparam int N      = DATA_W + PAR_W;
  localparam int CODE_W = N + 1;
  localparam logic [PAR_W-1:0] N_L = PAR_W'(N);

  if (DATA_W < 4 || DATA_W > 64) begin : g_bad_data_w
    $error("DATA_W must be within 4..64");
  end
  if ((2 ** PAR_W) < N + 1 || (2 ** (PAR_W - 1)) >= N) begin : g_bad_par_w
    $error("PAR_W must be the smallest p with 2^p >= DATA_W+p+1");
  end

  function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if (code[pos-1]) s = s ^ PAR_W'(pos);
    end
    return s;
  endfunction

  // Data bits sit at the non-power-of-two positions; shifting in from the MSB
  // leaves the lowest position in data[0].
  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) d = {code[pos-1], d[DATA_W-1:1]};
    end
    return d;
  endfunction

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s2_load_ok;
  logic              s1_advance;
  logic              delivered;

  assign s2_load_ok  = !bus.out_valid || bus.out_ready;
  assign s1_advance  = s1_valid && s2_load_ok;
  assign bus.in_ready = !s1_valid || s1_advance;
  assign delivered   = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code <= bus.in_code;
        s1_syn  <= syndrome(bus.in_code);
        s1_par  <= ^bus.in_code;
      end
    end
  end

  logic [CODE_W-1:0] fixed_code;
  logic              nxt_single;
  logic              nxt_double;

  always_comb begin
    fixed_code = s1_code;
    nxt_single = 1'b0;
    nxt_double = 1'b0;
    if (s1_syn == '0) begin
      nxt_single = s1_par;
    end else if (!s1_par || s1_syn > N_L) begin
      nxt_double = 1'b1;
    end else begin
      nxt_single = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (PAR_W'(i + 1) == s1_syn) fixed_code[i] = ~fixed_code[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.err_single <= 1'b0;
      bus.err_double <= 1'b0;
    end else if (s2_load_ok) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data   <= extract(fixed_code);
        bus.err_single <= nxt_single;
        bus.err_double <= nxt_double;
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (clr_counts) begin
      sec_count <= '0;
      ded_count <= '0;
    end else begin
      if (delivered && bus.err_single && sec_count != '1) sec_count <= sec_count + 1'b1;
      if (delivered && bus.err_double && ded_count != '1) ded_count <= ded_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// tb/tb_hamming_secded_decoder_pipe.sv - self-checking bench: directed vectors plus randomized error injection against a reference model
module tb_hamming_secded_decoder_pipe;
  localparam int DW = 8;
  localparam int PW = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          single;
    logic          double;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             clr_counts;
  logic [CNT_W-1:0] sec_count;
  logic [CNT_W-1:0] ded_count;

  hamming_secded_decoder_pipe_if #(.DATA_W(DW), .PAR_W(PW)) bus ();

  hamming_secded_decoder_pipe #(.DATA_W(DW), .PAR_W(PW), .COUNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_counts (clr_counts),
    .sec_count  (sec_count),
    .ded_count  (ded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   m_sec = 0;
  int   m_ded = 0;
  exp_t q[$];
  exp_t nxt;
  logic accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    int k;
    logic b;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      b = 1'b0;
      for (int pos = 1; pos <= 12; pos++) if ((pos & p) != 0 && pos != p) b ^= c[pos-1];
      c[p-1] = b;
    end
    c[12] = ^c[11:0];
    return c;
  endfunction

  function automatic logic [7:0] extract_ref(input logic [12:0] c);
    logic [7:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic s, input logic dd);
    exp_t e;
    e.data = d;
    e.single = s;
    e.double = dd;
    return e;
  endfunction

  // Random word with 0, 1 or 2 flipped bits; expectation follows from the flip count alone.
  task automatic gen(input int nf, output logic [12:0] c, output exp_t e);
    logic [7:0] d;
    int a, b;
    d = 8'($urandom);
    c = encode(d);
    a = $urandom_range(0, 12);
    b = (a + $urandom_range(1, 12)) % 13;
    if (nf >= 1) c[a] = ~c[a];
    if (nf == 2) c[b] = ~c[b];
    if (nf == 0) e = mk(d, 1'b0, 1'b0);
    else if (nf == 1) e = mk(d, 1'b1, 1'b0);
    else e = mk(extract_ref(c), 1'b0, 1'b1);
  endtask

  task automatic cycle();
    logic inc_s, inc_d;
    @(negedge clk);
    check("sec_count", 64'(sec_count), 64'(m_sec));
    check("ded_count", 64'(ded_count), 64'(m_ded));
    inc_s = 1'b0;
    inc_d = 1'b0;
    accepted = bus.in_valid && bus.in_ready;
    if (accepted) q.push_back(nxt);
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 64'(bus.out_valid), 64'(0));
      end else begin
        check("out_data", 64'(bus.out_data), 64'(q[0].data));
        check("err_single", 64'(bus.err_single), 64'(q[0].single));
        check("err_double", 64'(bus.err_double), 64'(q[0].double));
        if (bus.out_ready) begin
          inc_s = q[0].single;
          inc_d = q[0].double;
          void'(q.pop_front());
        end
      end
    end
    if (clr_counts) begin
      m_sec = 0;
      m_ded = 0;
    end else begin
      if (inc_s && m_sec < CNT_MAX) m_sec++;
      if (inc_d && m_ded < CNT_MAX) m_ded++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [12:0] c, input exp_t e);
    int n;
    bus.in_valid = 1'b1;
    bus.in_code = c;
    nxt = e;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 50);
    check("send_accept", 64'(accepted), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
    check("drain_remaining", 64'(q.size()), 64'(0));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sec_count", 64'(sec_count), 64'(0));
    check("rst_ded_count", 64'(ded_count), 64'(0));
    q.delete();
    m_sec = 0;
    m_ded = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
  endtask

  logic [12:0] code;
  exp_t        e;
  logic [12:0] words [5];
  exp_t        wexp [5];
  int          idx;
  int          sat_tbl [4] = '{1, 2, 3, 3};

  initial begin
    rst_n = 1'b1;
    clr_counts = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_data", 64'(bus.out_data), 64'(0));
    check("reset_sec", 64'(sec_count), 64'(0));
    rst_n = 1'b1;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));

    // Clean word and pipeline latency
    bus.out_ready = 1'b1;
    bus.in_code = 13'h0A27;
    nxt = mk(8'hA5, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    cycle();
    check("t1_accept", 64'(accepted), 64'(1));
    bus.in_valid = 1'b0;
    cycle();
    check("t1_latency_valid", 64'(bus.out_valid), 64'(1));
    drain();

    send_one(13'h0A07, mk(8'hA5, 1'b1, 1'b0));
    drain();
    check("t2_sec_count", 64'(sec_count), 64'(1));
    send_one(13'h1A27, mk(8'hA5, 1'b1, 1'b0));
    drain();
    check("t2_sec_count_overall", 64'(sec_count), 64'(2));

    send_one(13'h0A24, mk(8'hA5, 1'b0, 1'b1));
    drain();
    check("t3_ded_count", 64'(ded_count), 64'(1));
    send_one(13'h0AAE, mk(8'hA5, 1'b0, 1'b1));
    drain();
    check("t3_ded_invalid_pos", 64'(ded_count), 64'(2));

    // Five-word stream with a four-cycle consumer stall
    for (int i = 0; i < 5; i++) gen(0, words[i], wexp[i]);
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 5 || q.size() > 0); cyc++) begin
      bus.in_valid = (idx < 5);
      if (idx < 5) begin
        bus.in_code = words[idx];
        nxt = wexp[idx];
      end
      bus.out_ready = !(cyc >= 3 && cyc < 7);
      if (cyc >= 4 && cyc < 7) begin
        #1;
        check("t4_in_ready_stalled", 64'(bus.in_ready), 64'(0));
      end
      cycle();
      if (accepted) idx++;
    end
    check("t4_all_sent", 64'(idx), 64'(5));
    check("t4_all_out", 64'(q.size()), 64'(0));

    // Random traffic, random backpressure and occasional clears
    gen($urandom_range(0, 2), code, e);
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_code = code;
      nxt = e;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_counts = ($urandom_range(0, 15) == 0);
      cycle();
      if (accepted) gen($urandom_range(0, 2), code, e);
    end
    clr_counts = 1'b0;
    drain();

    // Saturation and clear priority
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      gen(1, code, e);
      send_one(code, e);
      drain();
      check("t5_sec_sat", 64'(sec_count), 64'(sat_tbl[i]));
    end
    gen(1, code, e);
    send_one(code, e);
    cycle();
    check("t5_out_valid_before_clr", 64'(bus.out_valid), 64'(1));
    clr_counts = 1'b1;
    cycle();
    clr_counts = 1'b0;
    check("t5_clr_priority", 64'(sec_count), 64'(0));
    gen(2, code, e);
    send_one(code, e);
    drain();
    check("t5_ded_before_reset", 64'(ded_count), 64'(1));

    // Reset with two words in flight
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    gen(1, code, e);
    bus.in_code = code;
    nxt = e;
    cycle();
    gen(0, code, e);
    bus.in_code = code;
    nxt = e;
    cycle();
    bus.in_valid = 1'b0;
    #1;
    pulse_reset();
    gen(0, code, e);
    send_one(code, e);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
